// File: rtl/ascon_pack.sv
// Shared types and constants for the Ascon round-unit controller.
package ascon_pack;

  localparam int ROUND_WIDTH    = 4;
  localparam int PAD_AW         = 3;
  localparam int INIT_ROUNDS    = 12;
  localparam int PB_FIRST_ROUND = 6;

  // Round-unit operation issued alongside ru_en_o; OP_PERM is the idle encoding.
  typedef enum logic [2:0] {
    OP_PERM  = 3'd0,
    OP_INIT  = 3'd1,
    OP_AD    = 3'd2,
    OP_MSG   = 3'd3,
    OP_FINAL = 3'd4
  } ascon_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_AD_WAIT,
    ST_AD_PERM,
    ST_MSG_WAIT,
    ST_MSG_PERM,
    ST_FINAL,
    ST_TAG
  } ascon_state_e;

  localparam logic [ROUND_WIDTH-1:0] LAST_ROUND    = ROUND_WIDTH'(INIT_ROUNDS - 1);
  localparam logic [ROUND_WIDTH-1:0] PB_FIRST      = ROUND_WIDTH'(PB_FIRST_ROUND);
  localparam logic [ROUND_WIDTH-1:0] PB_PERM_FIRST = ROUND_WIDTH'(PB_FIRST_ROUND + 1);

endpackage

// File: rtl/ascon_round_ctrl.sv
// Ascon AEAD sequencer: walks init, AD absorb, message absorb, finalization
// and tag phases, driving round number/op/block index to the round unit.
module ascon_round_ctrl
  import ascon_pack::*;
#(
  parameter int BLOCK_AW = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic                   decrypt_i,
  input  logic [BLOCK_AW-1:0]    ad_blocks_i,
  input  logic [BLOCK_AW-1:0]    msg_blocks_i,
  input  logic                   blk_valid_i,
  input  logic [PAD_AW-1:0]      blk_pad_idx_i,
  output logic                   blk_ready_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic                   tag_valid_o,
  input  logic                   tag_ready_i,
  output logic                   busy_o,
  output logic                   ru_en_o,
  output ascon_op_e              ru_op_o,
  output logic [ROUND_WIDTH-1:0] ru_round_o,
  output logic [BLOCK_AW-1:0]    ru_blk_no_o,
  output logic [PAD_AW-1:0]      ru_pad_idx_o,
  output logic                   ru_decrypt_o
);

  ascon_state_e               state_q, state_d;
  logic [ROUND_WIDTH-1:0]     round_q, round_d;
  logic [BLOCK_AW-1:0]        blk_q, blk_d;
  logic [BLOCK_AW-1:0]        ad_cnt_q, ad_cnt_d;
  logic [BLOCK_AW-1:0]        msg_cnt_q, msg_cnt_d;
  logic                       dec_q, dec_d;

  // Block index compares against count-1, so a full-scale count never wraps.
  logic last_ad, last_msg, last_round;
  assign last_ad    = (blk_q == ad_cnt_q - BLOCK_AW'(1));
  assign last_msg   = (blk_q == msg_cnt_q - BLOCK_AW'(1));
  assign last_round = (round_q == LAST_ROUND);

  // State, counter and latch registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      round_q   <= '0;
      blk_q     <= '0;
      ad_cnt_q  <= '0;
      msg_cnt_q <= '0;
      dec_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      round_q   <= round_d;
      blk_q     <= blk_d;
      ad_cnt_q  <= ad_cnt_d;
      msg_cnt_q <= msg_cnt_d;
      dec_q     <= dec_d;
    end
  end

  // Next-state, counter updates and round-unit/handshake outputs.
  always_comb begin
    state_d      = state_q;
    round_d      = round_q;
    blk_d        = blk_q;
    ad_cnt_d     = ad_cnt_q;
    msg_cnt_d    = msg_cnt_q;
    dec_d        = dec_q;
    busy_o       = (state_q != ST_IDLE);
    blk_ready_o  = 1'b0;
    out_valid_o  = 1'b0;
    tag_valid_o  = 1'b0;
    ru_en_o      = 1'b0;
    ru_op_o      = OP_PERM;
    ru_round_o   = '0;
    ru_blk_no_o  = '0;
    ru_pad_idx_o = '0;
    ru_decrypt_o = busy_o & dec_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          ad_cnt_d  = ad_blocks_i;
          // An empty message still needs one padding block.
          msg_cnt_d = (msg_blocks_i == '0) ? BLOCK_AW'(1) : msg_blocks_i;
          dec_d     = decrypt_i;
          round_d   = '0;
          blk_d     = '0;
          state_d   = ST_INIT;
        end
      end
      ST_INIT, ST_FINAL: begin
        ru_en_o    = 1'b1;
        ru_round_o = round_q;
        if (round_q == '0) ru_op_o = (state_q == ST_INIT) ? OP_INIT : OP_FINAL;
        if (last_round) begin
          round_d = '0;
          blk_d   = '0;
          if (state_q == ST_FINAL)      state_d = ST_TAG;
          else if (ad_cnt_q != '0)      state_d = ST_AD_WAIT;
          else                          state_d = ST_MSG_WAIT;
        end else begin
          round_d = round_q + ROUND_WIDTH'(1);
        end
      end
      ST_AD_WAIT: begin
        blk_ready_o = 1'b1;
        ru_blk_no_o = blk_q;
        if (blk_valid_i) begin
          ru_en_o      = 1'b1;
          ru_op_o      = OP_AD;
          ru_round_o   = PB_FIRST;
          ru_pad_idx_o = blk_pad_idx_i;
          round_d      = PB_PERM_FIRST;
          state_d      = ST_AD_PERM;
        end
      end
      ST_MSG_WAIT: begin
        // Output is produced in the same cycle as the absorb, so both sides must agree.
        blk_ready_o = out_ready_i;
        out_valid_o = blk_valid_i;
        ru_blk_no_o = blk_q;
        if (blk_valid_i && out_ready_i) begin
          ru_en_o      = 1'b1;
          ru_op_o      = OP_MSG;
          ru_round_o   = PB_FIRST;
          ru_pad_idx_o = blk_pad_idx_i;
          if (last_msg) begin
            round_d = '0;
            state_d = ST_FINAL;
          end else begin
            round_d = PB_PERM_FIRST;
            state_d = ST_MSG_PERM;
          end
        end
      end
      ST_AD_PERM, ST_MSG_PERM: begin
        ru_en_o     = 1'b1;
        ru_round_o  = round_q;
        ru_blk_no_o = blk_q;
        if (last_round) begin
          round_d = '0;
          if (state_q == ST_AD_PERM && last_ad) begin
            blk_d   = '0;
            state_d = ST_MSG_WAIT;
          end else begin
            blk_d   = blk_q + BLOCK_AW'(1);
            state_d = (state_q == ST_AD_PERM) ? ST_AD_WAIT : ST_MSG_WAIT;
          end
        end else begin
          round_d = round_q + ROUND_WIDTH'(1);
        end
      end
      ST_TAG: begin
        tag_valid_o = 1'b1;
        if (tag_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ascon_round_ctrl.sv
// Directed bench for ascon_round_ctrl: cycle-indexed checks per scenario.
module tb_ascon_round_ctrl;
  import ascon_pack::*;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   start_i = 1'b0, decrypt_i = 1'b0;
  logic [3:0]             ad_blocks_i = '0, msg_blocks_i = '0;
  logic                   blk_valid_i = 1'b0;
  logic [PAD_AW-1:0]      blk_pad_idx_i = '0;
  logic                   blk_ready_o, out_valid_o, out_ready_i = 1'b0;
  logic                   tag_valid_o, tag_ready_i = 1'b0, busy_o;
  logic                   ru_en_o, ru_decrypt_o;
  ascon_op_e              ru_op_o;
  logic [ROUND_WIDTH-1:0] ru_round_o;
  logic [3:0]             ru_blk_no_o;
  logic [PAD_AW-1:0]      ru_pad_idx_o;

  ascon_round_ctrl #(.BLOCK_AW(4)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .decrypt_i(decrypt_i),
    .ad_blocks_i(ad_blocks_i), .msg_blocks_i(msg_blocks_i),
    .blk_valid_i(blk_valid_i), .blk_pad_idx_i(blk_pad_idx_i), .blk_ready_o(blk_ready_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .tag_valid_o(tag_valid_o), .tag_ready_i(tag_ready_i), .busy_o(busy_o),
    .ru_en_o(ru_en_o), .ru_op_o(ru_op_o), .ru_round_o(ru_round_o),
    .ru_blk_no_o(ru_blk_no_o), .ru_pad_idx_o(ru_pad_idx_o), .ru_decrypt_o(ru_decrypt_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Absorb log: block numbers per phase and length of the PERM run after each absorb.
  bit mon_on = 1'b0;
  int ad_blk_q[$];
  int msg_blk_q[$];
  int run_q[$];
  int run = 0;
  bit pending = 1'b0;
  int final_cnt = 0;

  initial forever begin
    @(negedge clk);
    if (mon_on) begin
      if (ru_en_o && (ru_op_o == OP_AD || ru_op_o == OP_MSG)) begin
        if (pending) run_q.push_back(run);
        if (ru_op_o == OP_AD) ad_blk_q.push_back(int'(ru_blk_no_o));
        else                  msg_blk_q.push_back(int'(ru_blk_no_o));
        pending = 1'b1;
        run = 0;
      end else if (ru_en_o && ru_op_o == OP_PERM) begin
        if (pending) run++;
      end else if (pending) begin
        run_q.push_back(run);
        pending = 1'b0;
      end
      if (ru_en_o && ru_op_o == OP_FINAL) final_cnt++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mon_clear;
    ad_blk_q.delete();
    msg_blk_q.delete();
    run_q.delete();
    pending = 1'b0;
    run = 0;
    final_cnt = 0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    start_i = 1'b0; blk_valid_i = 1'b0; out_ready_i = 1'b0; tag_ready_i = 1'b0;
    tick; tick;
    rst = 1'b0;
  endtask

  // Runs one operation with every handshake ready; tag_cyc = cycle index of tag_valid_o.
  task automatic run_op(input int ad, input int msg, output int tag_cyc);
    ad_blocks_i = 4'(ad); msg_blocks_i = 4'(msg); decrypt_i = 1'b0;
    blk_pad_idx_i = 3'd3; blk_valid_i = 1'b1; out_ready_i = 1'b1; tag_ready_i = 1'b1;
    start_i = 1'b1;
    tag_cyc = -1;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (tag_valid_o) begin
        tag_cyc = i;
        tick;
        start_i = 1'b0;
        break;
      end
      tick;
      start_i = 1'b0;
    end
    blk_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    logic [19:0] got;
    rst = 1'b1; start_i = 1'b1; blk_valid_i = 1'b1; out_ready_i = 1'b1; tag_ready_i = 1'b1;
    tick;
    #1;
    got = {busy_o, ru_en_o, blk_ready_o, out_valid_o, tag_valid_o, ru_decrypt_o,
           ru_op_o, ru_round_o, ru_blk_no_o, ru_pad_idx_o};
    total++;
    if (got !== 20'd0) begin bad++; $display("FAIL reset_outputs got=%h want=0", got); end
    rst = 1'b0; start_i = 1'b0; blk_valid_i = 1'b0;
  endtask

  // ad=0, msg=1: absorb at cycle 13, FINAL 14..25, tag at 26, idle at 27.
  task automatic test_basic;
    logic [20:0] got;
    int tag_cyc;
    do_reset;
    ad_blocks_i = 4'd0; msg_blocks_i = 4'd1; decrypt_i = 1'b1; blk_pad_idx_i = 3'd5;
    blk_valid_i = 1'b1; out_ready_i = 1'b1; tag_ready_i = 1'b1; start_i = 1'b1;
    tag_cyc = -1;
    for (int i = 0; i <= 27; i++) begin
      #1;
      if (i == 1) begin
        total++;
        if ({ru_en_o, ru_op_o, ru_round_o} !== {1'b1, OP_INIT, 4'd0}) begin
          bad++; $display("FAIL basic_init_r0 got=%b want=%b", {ru_en_o, ru_op_o, ru_round_o}, {1'b1, OP_INIT, 4'd0});
        end
      end
      if (i >= 2 && i <= 12) begin
        total++;
        if ({ru_en_o, ru_op_o, ru_round_o, blk_ready_o, out_valid_o, ru_pad_idx_o} !==
            {1'b1, OP_PERM, 4'(i - 1), 1'b0, 1'b0, 3'd0}) begin
          bad++; $display("FAIL basic_init_round cyc=%0d en=%b op=%0d round=%0d rdy=%b ov=%b want round=%0d", i,
                          ru_en_o, ru_op_o, ru_round_o, blk_ready_o, out_valid_o, i - 1);
        end
      end
      if (i == 13) begin
        got = {ru_en_o, ru_op_o, ru_round_o, ru_pad_idx_o, ru_blk_no_o, out_valid_o, blk_ready_o, ru_decrypt_o, busy_o};
        total++;
        if (got !== {1'b1, OP_MSG, 4'd6, 3'd5, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1}) begin
          bad++; $display("FAIL basic_absorb got=%h want=%h", got, {1'b1, OP_MSG, 4'd6, 3'd5, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1});
        end
      end
      if (i == 14) begin
        total++;
        if ({ru_en_o, ru_op_o, ru_round_o, blk_ready_o} !== {1'b1, OP_FINAL, 4'd0, 1'b0}) begin
          bad++; $display("FAIL basic_final_r0 op=%0d round=%0d rdy=%b", ru_op_o, ru_round_o, blk_ready_o);
        end
      end
      if (i == 25) begin
        total++;
        if ({ru_op_o, ru_round_o} !== {OP_PERM, 4'd11}) begin
          bad++; $display("FAIL basic_final_r11 op=%0d round=%0d want 0/11", ru_op_o, ru_round_o);
        end
      end
      if (tag_valid_o && tag_cyc < 0) tag_cyc = i;
      if (i == 27) begin
        total++;
        if ({busy_o, tag_valid_o, ru_en_o} !== 3'b000) begin
          bad++; $display("FAIL basic_idle busy=%b tv=%b en=%b want 000", busy_o, tag_valid_o, ru_en_o);
        end
      end
      tick;
      start_i = 1'b0;
    end
    total++;
    if (tag_cyc !== 26) begin bad++; $display("FAIL basic_tag_cycle got=%0d want=26", tag_cyc); end
    blk_valid_i = 1'b0;
  endtask

  // ad=2, msg=3: block sequences, PERM runs and overall latency.
  task automatic test_multi;
    int tag_cyc;
    int exp_run[5] = '{5, 5, 5, 5, 0};
    do_reset;
    mon_clear;
    mon_on = 1'b1;
    run_op(2, 3, tag_cyc);
    mon_on = 1'b0;
    total++;
    if (tag_cyc !== 50) begin bad++; $display("FAIL multi_tag_cycle got=%0d want=50", tag_cyc); end
    total++;
    if (ad_blk_q.size() != 2 || msg_blk_q.size() != 3 || run_q.size() != 5) begin
      bad++; $display("FAIL multi_counts ad=%0d msg=%0d runs=%0d want 2/3/5", ad_blk_q.size(), msg_blk_q.size(), run_q.size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        total++;
        if (ad_blk_q[k] != k) begin bad++; $display("FAIL multi_ad_blk idx=%0d got=%0d want=%0d", k, ad_blk_q[k], k); end
      end
      for (int k = 0; k < 3; k++) begin
        total++;
        if (msg_blk_q[k] != k) begin bad++; $display("FAIL multi_msg_blk idx=%0d got=%0d want=%0d", k, msg_blk_q[k], k); end
      end
      for (int k = 0; k < 5; k++) begin
        total++;
        if (run_q[k] != exp_run[k]) begin bad++; $display("FAIL multi_perm_run idx=%0d got=%0d want=%0d", k, run_q[k], exp_run[k]); end
      end
    end
    total++;
    if (final_cnt != 1) begin bad++; $display("FAIL multi_final_ops got=%0d want=1", final_cnt); end
  endtask

  // ad=0, msg=2: out_ready low for cycles 13..16 stalls the first message absorb.
  task automatic test_backpressure;
    int tag_cyc = -1;
    do_reset;
    ad_blocks_i = 4'd0; msg_blocks_i = 4'd2; decrypt_i = 1'b0; blk_pad_idx_i = 3'd0;
    blk_valid_i = 1'b1; tag_ready_i = 1'b1; start_i = 1'b1;
    for (int i = 0; i <= 38; i++) begin
      out_ready_i = !(i >= 13 && i <= 16);
      #1;
      if (i >= 13 && i <= 16) begin
        total++;
        if ({blk_ready_o, ru_en_o, out_valid_o, busy_o, ru_op_o, ru_blk_no_o} !== {4'b0011, OP_PERM, 4'd0}) begin
          bad++; $display("FAIL bp_stall cyc=%0d rdy=%b en=%b ov=%b busy=%b blk=%0d", i, blk_ready_o, ru_en_o, out_valid_o, busy_o, ru_blk_no_o);
        end
      end
      if (i == 17 || i == 23) begin
        total++;
        if ({ru_en_o, ru_op_o, ru_round_o, ru_blk_no_o} !== {1'b1, OP_MSG, 4'd6, 4'((i - 17) / 6)}) begin
          bad++; $display("FAIL bp_absorb cyc=%0d en=%b op=%0d round=%0d blk=%0d", i, ru_en_o, ru_op_o, ru_round_o, ru_blk_no_o);
        end
      end
      if (i == 18) begin
        total++;
        if ({ru_op_o, ru_round_o} !== {OP_PERM, 4'd7}) begin
          bad++; $display("FAIL bp_perm7 op=%0d round=%0d want 0/7", ru_op_o, ru_round_o);
        end
      end
      if (i == 24) begin
        total++;
        if (ru_op_o !== OP_FINAL) begin bad++; $display("FAIL bp_final op=%0d want=%0d", ru_op_o, OP_FINAL); end
      end
      if (tag_valid_o && tag_cyc < 0) tag_cyc = i;
      tick;
      start_i = 1'b0;
    end
    total++;
    if (tag_cyc !== 36) begin bad++; $display("FAIL bp_tag_cycle got=%0d want=36", tag_cyc); end
    blk_valid_i = 1'b0;
  endtask

  // Reset during FINAL round 5 aborts; a fresh ad=1,msg=1 op then completes normally.
  task automatic test_reset_mid;
    logic [19:0] got;
    int leaks = 0;
    int tag_cyc;
    do_reset;
    ad_blocks_i = 4'd0; msg_blocks_i = 4'd1; blk_valid_i = 1'b1; out_ready_i = 1'b1;
    tag_ready_i = 1'b1; start_i = 1'b1;
    for (int i = 0; i <= 19; i++) begin
      #1;
      if (i == 19) begin
        total++;
        if ({ru_en_o, ru_op_o, ru_round_o} !== {1'b1, OP_PERM, 4'd5}) begin
          bad++; $display("FAIL rstmid_round5 en=%b op=%0d round=%0d", ru_en_o, ru_op_o, ru_round_o);
        end
        rst = 1'b1;
      end
      tick;
      start_i = 1'b0;
    end
    rst = 1'b0;
    #1;
    got = {busy_o, ru_en_o, blk_ready_o, out_valid_o, tag_valid_o, ru_decrypt_o,
           ru_op_o, ru_round_o, ru_blk_no_o, ru_pad_idx_o};
    total++;
    if (got !== 20'd0) begin bad++; $display("FAIL rstmid_outputs got=%h want=0", got); end
    for (int i = 0; i < 30; i++) begin
      if (tag_valid_o || out_valid_o || busy_o) leaks++;
      tick;
    end
    total++;
    if (leaks != 0) begin bad++; $display("FAIL rstmid_quiet got=%0d want=0", leaks); end
    run_op(1, 1, tag_cyc);
    total++;
    if (tag_cyc !== 32) begin bad++; $display("FAIL rstmid_restart_tag got=%0d want=32", tag_cyc); end
  endtask

  // Start pulsed in INIT with new counts is ignored; msg=0 processes one block.
  task automatic test_start_ignore;
    int tag_cyc = -1;
    do_reset;
    mon_clear;
    mon_on = 1'b1;
    ad_blocks_i = 4'd0; msg_blocks_i = 4'd0; blk_valid_i = 1'b1; out_ready_i = 1'b1; tag_ready_i = 1'b1;
    for (int i = 0; i <= 27; i++) begin
      start_i = (i == 0 || i == 5);
      if (i == 5) begin ad_blocks_i = 4'd3; msg_blocks_i = 4'd5; end
      #1;
      if (i == 6) begin
        total++;
        if ({ru_op_o, ru_round_o} !== {OP_PERM, 4'd5}) begin
          bad++; $display("FAIL ign_round op=%0d round=%0d want 0/5", ru_op_o, ru_round_o);
        end
      end
      if (i == 13) begin
        total++;
        if ({ru_en_o, ru_op_o} !== {1'b1, OP_MSG}) begin
          bad++; $display("FAIL ign_absorb en=%b op=%0d want 1/%0d", ru_en_o, ru_op_o, OP_MSG);
        end
      end
      if (tag_valid_o && tag_cyc < 0) tag_cyc = i;
      tick;
    end
    start_i = 1'b0;
    mon_on = 1'b0;
    total++;
    if (tag_cyc !== 26) begin bad++; $display("FAIL ign_tag_cycle got=%0d want=26", tag_cyc); end
    total++;
    if (msg_blk_q.size() != 1 || ad_blk_q.size() != 0) begin
      bad++; $display("FAIL ign_blocks msg=%0d ad=%0d want 1/0", msg_blk_q.size(), ad_blk_q.size());
    end
    blk_valid_i = 1'b0;
  endtask

  // Tag held 10 cycles under backpressure, idle one cycle after tag_ready rises.
  task automatic test_tag_hold;
    do_reset;
    ad_blocks_i = 4'd0; msg_blocks_i = 4'd1; blk_valid_i = 1'b1; out_ready_i = 1'b1; start_i = 1'b1;
    for (int i = 0; i <= 37; i++) begin
      tag_ready_i = (i >= 36);
      #1;
      if (i >= 26 && i <= 36) begin
        total++;
        if ({tag_valid_o, busy_o, ru_en_o} !== 3'b110) begin
          bad++; $display("FAIL tag_hold cyc=%0d tv=%b busy=%b en=%b want 110", i, tag_valid_o, busy_o, ru_en_o);
        end
      end
      if (i == 37) begin
        total++;
        if ({tag_valid_o, busy_o} !== 2'b00) begin
          bad++; $display("FAIL tag_release tv=%b busy=%b want 00", tag_valid_o, busy_o);
        end
      end
      tick;
      start_i = 1'b0;
    end
    blk_valid_i = 1'b0;
  endtask

  // Full-scale counts (15/15) run without counter wrap.
  task automatic test_max_count;
    int tag_cyc;
    do_reset;
    mon_clear;
    mon_on = 1'b1;
    run_op(15, 15, tag_cyc);
    mon_on = 1'b0;
    total++;
    if (tag_cyc !== 200) begin bad++; $display("FAIL max_tag_cycle got=%0d want=200", tag_cyc); end
    total++;
    if (ad_blk_q.size() != 15 || msg_blk_q.size() != 15) begin
      bad++; $display("FAIL max_counts ad=%0d msg=%0d want 15/15", ad_blk_q.size(), msg_blk_q.size());
    end else begin
      total++;
      if (ad_blk_q[14] != 14 || msg_blk_q[14] != 14) begin
        bad++; $display("FAIL max_last_blk ad=%0d msg=%0d want 14/14", ad_blk_q[14], msg_blk_q[14]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_multi;
    test_backpressure;
    test_reset_mid;
    test_start_ignore;
    test_tag_hold;
    test_max_count;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
